// File: rtl/shift_add_mul.sv
// shift_add_mul: iterative shift-add multiplier; start/x/y/signed_mode in, busy/done/z(product) out
module shift_add_mul #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] z
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int CW = $clog2(WIDTH + 1);
  state_t             r_state;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_neg;
  logic [WIDTH-1:0]   w_xmag;
  logic [WIDTH-1:0]   w_ymag;
  logic               w_neg;
  always_comb begin
    w_xmag = (signed_mode && x[WIDTH-1]) ? -x : x;
    w_ymag = (signed_mode && y[WIDTH-1]) ? -y : y;
    w_neg  = signed_mode & (x[WIDTH-1] ^ y[WIDTH-1]);
  end
  assign busy = r_state == RUN;
  assign done = r_state == DONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state  <= IDLE;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      z        <= '0;
    end else if (r_state == RUN) begin
      if (r_cnt == CW'(WIDTH)) begin
        r_state <= DONE;
        z       <= r_neg ? -r_acc : r_acc;
      end else begin
        r_acc    <= r_mplier[0] ? r_acc + r_mcand : r_acc;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
      end
    end else if (start) begin
      r_state  <= RUN;
      r_mcand  <= {{WIDTH{1'b0}}, w_xmag};
      r_mplier <= w_ymag;
      r_neg    <= w_neg;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= IDLE;
    end
endmodule

// File: tb/tb_shift_add_mul.sv
// tb_shift_add_mul: scoreboard bench for shift_add_mul at WIDTH=32 and WIDTH=8
module tb_shift_add_mul;
  typedef struct {
    logic [63:0] z;
    int          t;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start32 = 1'b0, sm32 = 1'b0;
  logic [31:0] x32 = '0, y32 = '0;
  logic        busy32, done32;
  logic [63:0] z32;
  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  x8 = '0, y8 = '0;
  logic        busy8, done8;
  logic [15:0] z8;
  int          total = 0, bad = 0, cyc = 0, a0;
  exp_t        sb32[$], sb8[$];
  exp_t        e32, e8;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  shift_add_mul #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .start(start32), .signed_mode(sm32),
    .x(x32), .y(y32), .busy(busy32), .done(done32), .z(z32)
  );
  shift_add_mul #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .x(x8), .y(y8), .busy(busy8), .done(done8), .z(z8)
  );
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] model32(input logic sm, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = sm ? {{32{a[31]}}, a} : {32'b0, a};
    eb = sm ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction
  function automatic logic [63:0] model8(input logic sm, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] ea, eb, p;
    ea = sm ? {{8{a[7]}}, a} : {8'b0, a};
    eb = sm ? {{8{b[7]}}, b} : {8'b0, b};
    p  = ea * eb;
    return {48'b0, p};
  endfunction
  always @(posedge clk) begin
    #1;
    if (done32) begin
      if (sb32.size() == 0) check_eq("extra_done32", {63'b0, done32}, 64'd0);
      else begin
        e32 = sb32.pop_front();
        check_eq("z32", z32, e32.z);
        check_eq("lat32", 64'(cyc), 64'(e32.t));
      end
    end
    if (done8) begin
      if (sb8.size() == 0) check_eq("extra_done8", {63'b0, done8}, 64'd0);
      else begin
        e8 = sb8.pop_front();
        check_eq("z8", {48'b0, z8}, e8.z);
        check_eq("lat8", 64'(cyc), 64'(e8.t));
      end
    end
  end
  task automatic op32(input logic sm, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    sm32 = sm; x32 = a; y32 = b; start32 = 1'b1;
    @(posedge clk);
    #1;
    check_eq("accept32", {63'b0, busy32}, 64'd1);
    sb32.push_back('{model32(sm, a, b), cyc + 33});
    start32 = 1'b0; x32 = $urandom; y32 = $urandom; sm32 = ~sm;
  endtask
  task automatic op8(input logic sm, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    sm8 = sm; x8 = a; y8 = b; start8 = 1'b1;
    @(posedge clk);
    #1;
    check_eq("accept8", {63'b0, busy8}, 64'd1);
    sb8.push_back('{model8(sm, a, b), cyc + 9});
    start8 = 1'b0; x8 = 8'($urandom); y8 = 8'($urandom); sm8 = ~sm;
  endtask
  task automatic drain(input int n);
    for (int i = 0; i < n && (sb32.size() > 0 || sb8.size() > 0); i++) @(posedge clk);
    #2;
    check_eq("drain32", 64'(sb32.size()), 64'd0);
    check_eq("drain8", 64'(sb8.size()), 64'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    #1;
    check_eq("rst_busy32", {63'b0, busy32}, 64'd0);
    check_eq("rst_done32", {63'b0, done32}, 64'd0);
    check_eq("rst_z32", z32, 64'd0);
    check_eq("rst_z8", {48'b0, z8}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    op32(1'b0, 32'd17, 32'd7);
    drain(45);
    check_eq("const_17x7", z32, 64'd119);
    op32(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    drain(45);
    check_eq("const_ffxff", z32, 64'hFFFFFFFE00000001);
    op32(1'b1, 32'hFFFFFFFD, 32'd5);
    drain(45);
    check_eq("const_m3x5", z32, 64'hFFFFFFFFFFFFFFF1);
    op32(1'b1, 32'h80000000, 32'h80000000);
    drain(45);
    check_eq("const_minxmin", z32, 64'h4000000000000000);
    op8(1'b1, 8'h80, 8'hFF);
    drain(15);
    check_eq("const8_80xff", {48'b0, z8}, 64'h0080);
    op8(1'b0, 8'hFF, 8'hFF);
    drain(15);
    check_eq("const8_255sq", {48'b0, z8}, 64'd65025);
    op8(1'b0, 8'h00, 8'h9C);
    drain(15);
    op32(1'b1, 32'd0, 32'h80000000);
    drain(45);
    for (int i = 0; i < 4; i++) begin
      op32(1'($urandom), $urandom, $urandom);
      drain(45);
      op8(1'($urandom), 8'($urandom), 8'($urandom));
      drain(15);
    end
    op32(1'b0, 32'd17, 32'd7);
    repeat (5) @(negedge clk);
    start32 = 1'b1; x32 = 32'd99; y32 = 32'd3;
    @(negedge clk);
    start32 = 1'b0;
    drain(45);
    repeat (3) @(negedge clk);
    check_eq("hold_z32", z32, 64'd119);
    check_eq("done_low32", {63'b0, done32}, 64'd0);
    @(negedge clk);
    sm32 = 1'b0; x32 = 32'd1000; y32 = 32'd3000; start32 = 1'b1;
    @(posedge clk);
    #1;
    a0 = cyc;
    sb32.push_back('{model32(1'b0, 32'd1000, 32'd3000), cyc + 33});
    x32 = 32'hFFFF0001; y32 = 32'd7; sm32 = 1'b1;
    repeat (34) @(posedge clk);
    #1;
    check_eq("b2b_edge", 64'(cyc), 64'(a0 + 34));
    check_eq("b2b_busy", {63'b0, busy32}, 64'd1);
    sb32.push_back('{model32(1'b1, 32'hFFFF0001, 32'd7), cyc + 33});
    start32 = 1'b0;
    drain(45);
    check_eq("b2b_z", z32, 64'hFFFFFFFFFFF90007);
    op32(1'b0, 32'hDEADBEEF, 32'h00012345);
    op8(1'b0, 8'd200, 8'd100);
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_busy32", {63'b0, busy32}, 64'd0);
    check_eq("arst_done32", {63'b0, done32}, 64'd0);
    check_eq("arst_z32", z32, 64'd0);
    check_eq("arst_busy8", {63'b0, busy8}, 64'd0);
    check_eq("arst_z8", {48'b0, z8}, 64'd0);
    sb32.delete();
    sb8.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("arst_zhold32", z32, 64'd0);
    op32(1'b1, 32'd100, 32'hFFFFFF38);
    drain(45);
    check_eq("post_rst_z32", z32, 64'hFFFFFFFFFFFFB1E0);
    op8(1'b1, 8'd5, 8'hFD);
    drain(15);
    check_eq("post_rst_z8", {48'b0, z8}, 64'hFFF1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shift_add_mul.md
SHIFT_ADD_MUL -- requirements
Module: shift_add_mul

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits; legal values are 4 to 64.
REQ-002 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit wide: reset, asynchronous and active-high.
REQ-004 Port start SHALL be an input, 1 bit wide: request to begin a multiply.
REQ-005 Port signed_mode SHALL be an input, 1 bit wide: 1 means two's-complement operands, 0 means unsigned.
REQ-006 Port x SHALL be an input, WIDTH bits wide: multiplicand.
REQ-007 Port y SHALL be an input, WIDTH bits wide: multiplier.
REQ-008 Port busy SHALL be an output, 1 bit wide: high while an operation is in progress.
REQ-009 Port done SHALL be an output, 1 bit wide: one-cycle pulse marking that z holds a new result.
REQ-010 Port z SHALL be an output, 2*WIDTH bits wide: registered product.

Function
REQ-011 The block SHALL implement an iterative shift-add multiplier with FSM states IDLE, RUN and DONE.
REQ-012 A request SHALL be accepted at a rising edge where start=1 and busy=0, i.e. in state IDLE or DONE.
REQ-013 At the accepting edge, the block SHALL capture x, y and signed_mode into internal registers, clear the accumulator and bit counter, and enter RUN.
REQ-014 The block SHALL ignore input changes after acceptance; the result depends only on the captured values.
REQ-015 In signed mode, captured operands SHALL be converted to magnitudes, and the sign flag SHALL be set to x[WIDTH-1] XOR y[WIDTH-1].
REQ-016 The magnitude of -2^(WIDTH-1) SHALL be 2^(WIDTH-1), with no overflow.
REQ-017 Each RUN cycle SHALL examine one multiplier bit, LSB first, and add the shifted multiplicand into a 2*WIDTH-bit accumulator when that bit is 1.
REQ-018 RUN SHALL process all WIDTH bits, including bit WIDTH-1: exactly WIDTH RUN cycles.
REQ-019 After the WIDTH-th RUN cycle, the block SHALL enter DONE.
REQ-020 On the edge entering DONE, z SHALL be loaded with the accumulator; if the sign flag is set, z SHALL instead be loaded with its two's-complement negation, modulo 2^(2*WIDTH).
REQ-021 done SHALL be 1 only in state DONE, so it is exactly one cycle wide.
REQ-022 done SHALL first be high WIDTH+1 rising edges after the accepting edge.
REQ-023 busy SHALL be 1 only in state RUN.
REQ-024 From DONE, the block SHALL go to RUN if start=1 (back-to-back accept), otherwise to IDLE.
REQ-025 A start asserted while busy=1 SHALL be ignored; it SHALL NOT be queued, and the current operation SHALL NOT be disturbed.
REQ-026 z SHALL hold its value at all times except the load on entry to DONE and reset.
REQ-027 The result SHALL equal the exact mathematical product for every operand pair in both modes; no truncation or overflow is possible within 2*WIDTH bits.
REQ-028 A zero operand SHALL still take the full WIDTH RUN cycles; there is no early termination.

Reset
REQ-029 While rst=1, independent of clk, the state SHALL be IDLE, busy=0, done=0, z=0, and the accumulator, counter and captured operands SHALL be 0.
REQ-030 Reset asserted mid-RUN or in DONE SHALL abort the operation, produce no done pulse, and leave z=0.
REQ-031 After rst deasserts, the first acceptance SHALL be possible at the next rising edge where start=1.

Verification
REQ-032 The bench SHALL cover: WIDTH=32, unsigned, x=17, y=7 -> done after 33 edges, z=119.
REQ-033 The bench SHALL cover: WIDTH=32, unsigned, x=y=32'hFFFFFFFF -> z=64'hFFFFFFFE00000001; this checks top-bit processing.
REQ-034 The bench SHALL cover: WIDTH=32, signed, x=-3, y=5 -> z=64'hFFFFFFFFFFFFFFF1; then x=y=32'h80000000 -> z=64'h4000000000000000.
REQ-035 The bench SHALL cover: WIDTH=8, signed, x=8'h80, y=8'hFF -> z=16'h0080; then unsigned x=y=255 -> z=65025, and done exactly 9 edges after acceptance.
REQ-036 The bench SHALL cover: start pulsed again mid-RUN with different operands -> first result unchanged, no extra done; start held high through DONE -> second operation accepted back-to-back with correct product.
REQ-037 The bench SHALL cover: rst asserted asynchronously mid-RUN -> busy, done and z go to 0 immediately, no done pulse; the next operation after release is correct.
